// File: rtl/bdd_eval_engine.sv
// BDD evaluation engine: walks a binary decision diagram stored in an external
// synchronous SRAM from a root node under a variable assignment, with a node-load port.
module bdd_eval_engine #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NVARS      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_root,
  input  logic [NVARS-1:0]      i_assign,
  input  logic                  i_load_valid,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic                  o_load_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_result,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_steps,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_write,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  input  logic [DATA_WIDTH-1:0] i_sram_data
);

  localparam int unsigned VAR_W  = (NVARS > 1) ? $clog2(NVARS) : 1;
  localparam int unsigned STEP_W = ADDR_WIDTH + 1;
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] node_q, node_d;
  logic [NVARS-1:0]      assign_q, assign_d;
  logic [STEP_W-1:0]     steps_q, steps_d;
  logic                  result_q, result_d;
  logic                  error_q, error_d;
  logic                  busy_q, done_q;

  // Node word fields
  logic                  word_term;
  logic                  word_val;
  logic [VAR_W-1:0]      word_var;
  logic [ADDR_WIDTH-1:0] word_hi;
  logic [ADDR_WIDTH-1:0] word_lo;
  logic                  unused_word_bits;

  assign word_term        = i_sram_data[DATA_WIDTH-1];
  assign word_val         = i_sram_data[DATA_WIDTH-2];
  assign word_var         = i_sram_data[2*ADDR_WIDTH +: VAR_W];
  assign word_hi          = i_sram_data[ADDR_WIDTH +: ADDR_WIDTH];
  assign word_lo          = i_sram_data[0 +: ADDR_WIDTH];
  assign unused_word_bits = ^i_sram_data[DATA_WIDTH-3:2*ADDR_WIDTH+VAR_W];

  // A start request always takes priority over a pending load
  logic load_go;
  assign o_load_ready = (state_q == IDLE) && !i_start;
  assign load_go      = i_rst_n && o_load_ready && i_load_valid;

  // SRAM port: loads own it in IDLE, the walker owns it while busy
  always_comb begin
    o_sram_write = 1'b0;
    o_sram_addr  = '0;
    o_sram_data  = '0;
    if (load_go) begin
      o_sram_write = 1'b1;
      o_sram_addr  = i_load_addr;
      o_sram_data  = i_load_data;
    end else if (state_q == ISSUE || state_q == WAIT) begin
      o_sram_addr  = node_q;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    node_d   = node_q;
    assign_d = assign_q;
    steps_d  = steps_q;
    result_d = result_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          node_d   = i_root;
          assign_d = i_assign;
          steps_d  = '0;
          result_d = 1'b0;
          error_d  = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (word_term) begin
          result_d = word_val;
          state_d  = DONE;
        end else if (steps_q == STEP_LIMIT) begin
          result_d = 1'b0;
          error_d  = 1'b1;
          state_d  = DONE;
        end else begin
          node_d  = assign_q[word_var] ? word_hi : word_lo;
          steps_d = steps_q + STEP_W'(1);
          state_d = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      node_q   <= '0;
      assign_q <= '0;
      steps_q  <= '0;
      result_q <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      node_q   <= node_d;
      assign_q <= assign_d;
      steps_q  <= steps_d;
      result_q <= result_d;
      error_q  <= error_d;
      busy_q   <= (state_d == ISSUE) || (state_d == WAIT);
      done_q   <= (state_d == DONE);
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_error  = error_q;
  assign o_steps  = steps_q;

endmodule

// File: tb/tb_bdd_eval_engine.sv
// Scoreboard bench for bdd_eval_engine: SRAM model, reference BDD walker,
// expected results queued at start and compared on each done pulse.
module tb_bdd_eval_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  root;
  logic [7:0]  asg;
  logic        load_valid;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        busy;
  logic        done;
  logic        result;
  logic        error;
  logic [4:0]  steps;
  logic [3:0]  sram_addr;
  logic        sram_write;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  bdd_eval_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NVARS(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_root       (root),
    .i_assign     (asg),
    .i_load_valid (load_valid),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .o_load_ready (load_ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_result     (result),
    .o_error      (error),
    .o_steps      (steps),
    .o_sram_addr  (sram_addr),
    .o_sram_write (sram_write),
    .o_sram_data  (sram_wdata),
    .i_sram_data  (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port SRAM: read data appears the cycle after the address edge
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (sram_write) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  typedef struct {
    logic       res;
    logic       err;
    logic [4:0] steps;
    int         lat;
    int         start_c;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] shadow [16];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ncyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference walker over the bench's own copy of memory
  function automatic exp_t model(input logic [3:0] r, input logic [7:0] a);
    exp_t        e;
    logic [3:0]  node;
    logic [31:0] w;
    int          k;
    node = r; k = 0;
    e.res = 1'b0; e.err = 1'b0; e.steps = '0; e.start_c = 0;
    for (int i = 0; i < 64; i++) begin
      w = shadow[node];
      k++;
      if (w[31]) begin
        e.res = w[30];
        break;
      end
      if (e.steps == 5'd16) begin
        e.err = 1'b1;
        break;
      end
      node = a[w[10:8]] ? w[7:4] : w[3:0];
      e.steps = e.steps + 5'd1;
    end
    e.lat = 2 * k + 1;
    return e;
  endfunction

  // Output monitor: cycle counter, scoreboard compare, write-while-busy guard
  always @(negedge clk) begin
    exp_t e;
    ncyc = ncyc + 1;
    if (busy) check("no_write_busy", {31'd0, sram_write}, 32'd0);
    if (done) begin
      check("busy_in_done", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result",   {31'd0, result}, {31'd0, e.res});
        check("error",    {31'd0, error},  {31'd0, e.err});
        check("steps",    {27'd0, steps},  {27'd0, e.steps});
        check("done_cyc", 32'(ncyc - e.start_c), 32'(e.lat));
      end
    end
  end

  task automatic load_word(input logic [3:0] a, input logic [31:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    #1;
    check("load_write", {31'd0, sram_write}, 32'd1);
    @(posedge clk); #1;
    load_valid = 1'b0;
    shadow[a] = d;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Start, then poke i_start and i_assign while busy to show they are ignored
  task automatic run_eval(input logic [3:0] r, input logic [7:0] a);
    exp_t e;
    e = model(r, a);
    start = 1'b1; root = r; asg = a;
    @(posedge clk); #1;
    e.start_c = ncyc;
    sb.push_back(e);
    check("issue_addr", {28'd0, sram_addr}, {28'd0, r});
    check("busy_start", {31'd0, busy}, 32'd1);
    asg = ~a;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    exp_t e;
    start = 1'b0; root = '0; asg = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    #12;
    check("rst_busy",   {31'd0, busy},       32'd0);
    check("rst_done",   {31'd0, done},       32'd0);
    check("rst_steps",  {27'd0, steps},      32'd0);
    check("rst_write",  {31'd0, sram_write}, 32'd0);
    check("rst_ready",  {31'd0, load_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) load_word(4'(i), 32'h0);
    load_word(4'd0, 32'h0000_0012);
    load_word(4'd1, 32'hC000_0000);
    load_word(4'd2, 32'h8000_0000);
    load_word(4'd3, 32'h0000_0033);
    load_word(4'd4, 32'h0000_0102);

    run_eval(4'd0, 8'h01);
    run_eval(4'd0, 8'h00);
    run_eval(4'd1, 8'h00);
    run_eval(4'd3, 8'h00);
    run_eval(4'd4, 8'h03);
    run_eval(4'd4, 8'h02);
    for (int i = 0; i < 4; i++) run_eval(4'd4, 8'($urandom));

    // Start collides with a load: start wins, the load lands after DONE
    start = 1'b1; root = 4'd0; asg = 8'h01;
    load_valid = 1'b1; load_addr = 4'd5; load_data = 32'hC000_0000;
    #1;
    check("collide_ready", {31'd0, load_ready}, 32'd0);
    check("collide_write", {31'd0, sram_write}, 32'd0);
    e = model(4'd0, 8'h01);
    @(posedge clk); #1;
    e.start_c = ncyc;
    sb.push_back(e);
    start = 1'b0;
    wait_done();
    check("late_write", {31'd0, sram_write}, 32'd1);
    check("late_addr",  {28'd0, sram_addr},  32'd5);
    check("late_data",  sram_wdata,          32'hC000_0000);
    @(posedge clk); #1;
    load_valid = 1'b0;
    shadow[5] = 32'hC000_0000;
    run_eval(4'd5, 8'h00);

    // Reset during WAIT aborts the walk
    run_eval(4'd0, 8'h01);
    start = 1'b1; root = 4'd0; asg = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy",   {31'd0, busy},       32'd0);
    check("abort_done",   {31'd0, done},       32'd0);
    check("abort_result", {31'd0, result},     32'd0);
    check("abort_error",  {31'd0, error},      32'd0);
    check("abort_steps",  {27'd0, steps},      32'd0);
    check("abort_addr",   {28'd0, sram_addr},  32'd0);
    check("abort_write",  {31'd0, sram_write}, 32'd0);
    check("abort_data",   sram_wdata,          32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", {31'd0, done}, 32'd0);
    run_eval(4'd0, 8'h00);
    run_eval(4'd3, 8'h00);
    run_eval(4'd0, 8'h01);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bdd_eval_engine.md
BDD_EVAL_ENGINE -- requirements
Module: bdd_eval_engine

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 4, SRAM address width; DATA_WIDTH, default 32, node word width; NVARS, default 8, number of BDD variables.
REQ-002 SHALL have ports, clock and reset first:
  i_clk  input  1  single clock, rising edge.
  i_rst_n  input  1  reset, asynchronous assert, active-low.
  i_start  input  1  start-evaluation request.
  i_root  input  ADDR_WIDTH  root node address.
  i_assign  input  NVARS  variable assignment vector.
  i_load_valid  input  1  node-load write request.
  i_load_addr  input  ADDR_WIDTH  node-load address.
  i_load_data  input  DATA_WIDTH  node-load word.
  o_load_ready  output  1  load accepted this cycle.
  o_busy  output  1  evaluation in progress.
  o_done  output  1  one-cycle completion pulse.
  o_result  output  1  BDD function value.
  o_error  output  1  step limit exceeded.
  o_steps  output  ADDR_WIDTH+1  non-terminal nodes traversed.
  o_sram_addr  output  ADDR_WIDTH  to sram i_addr.
  o_sram_write  output  1  to sram i_write.
  o_sram_data  output  DATA_WIDTH  to sram i_data.
  i_sram_data  input  DATA_WIDTH  from sram o_data.
REQ-003 SHALL treat the sram as a synchronous single-port memory: i_sram_data is valid in the cycle after the address edge.

Function
REQ-004 Node word format: bit DATA_WIDTH-1 terminal flag; bit DATA_WIDTH-2 terminal value; bits [2*ADDR_WIDTH+2:2*ADDR_WIDTH] variable index (NVARS=8); bits [2*ADDR_WIDTH-1:ADDR_WIDTH] high child; bits [ADDR_WIDTH-1:0] low child.
REQ-005 State machine SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-006 IDLE: i_start=1 at an edge latches i_root and i_assign, clears o_steps, o_error and o_result, and enters ISSUE.
REQ-007 ISSUE: drive o_sram_addr = current node address with o_sram_write=0, then enter WAIT.
REQ-008 WAIT, terminal word: latch o_result = terminal value and enter DONE.
REQ-009 WAIT, non-terminal word: next address = high child if i_assign[var]=1 (latched copy), else low child; increment o_steps; enter ISSUE.
REQ-010 Each node costs exactly 2 cycles; for k fetched nodes, o_done SHALL assert in cycle 2k+1 after the start edge.
REQ-011 Step limit: a non-terminal decode while o_steps == 2**ADDR_WIDTH SHALL enter DONE with o_error=1 and o_result=0, with o_steps not incremented.
REQ-012 DONE: o_done=1 for exactly one cycle, then IDLE; o_result, o_error and o_steps hold until the next accepted start.
REQ-013 o_busy=1 in ISSUE and WAIT only.
REQ-014 o_load_ready = IDLE and not i_start (combinational); a load with i_load_valid and o_load_ready drives o_sram_write=1 with o_sram_addr=i_load_addr and o_sram_data=i_load_data in the same cycle.
REQ-015 Simultaneous i_start and i_load_valid in IDLE: start wins and the load stalls (o_load_ready=0).
REQ-016 i_start outside IDLE SHALL be ignored; i_assign changes during evaluation SHALL have no effect.
REQ-017 o_sram_write SHALL be 0 in every state except an accepted load cycle.

Reset
REQ-018 i_rst_n=0 SHALL immediately force IDLE and set every register and output to 0, including the o_sram_* outputs; o_load_ready follows the REQ-014 rule.
REQ-019 Reset mid-evaluation SHALL abort with no o_done pulse; after release the block accepts a new start.

Verification
REQ-020 Load the nodes: addr0=0x00000012 (var0, hi=1, lo=2), addr1=0xC0000000, addr2=0x80000000; root 0, i_assign=0x01 -> o_done in cycle 5, o_result=1, o_steps=1, o_error=0.
REQ-021 Same nodes with i_assign=0x00 -> o_result=0, o_steps=1.
REQ-022 Root 1 (terminal) -> o_done in cycle 3, o_result=1, o_steps=0.
REQ-023 Self-loop node addr3=0x00000033, root 3 -> o_error=1, o_result=0, o_steps=16, o_done in cycle 35.
REQ-024 Raise i_start and i_load_valid together in IDLE -> no write occurs and evaluation starts; a load held during evaluation is written in the first IDLE cycle after DONE.
REQ-025 Assert i_rst_n=0 in WAIT -> outputs are 0 with no o_done; a following start evaluates correctly.
